// File: rtl/modexp_seq_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: FSM state
// encodings and the width helpers used by the RTL and the bench.
package modexp_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_REDUCE = 3'd2,
      ST_SCAN   = 3'd3,
      ST_SQUARE = 3'd4,
      ST_MULT   = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   // Width of the modular-multiply operands: wide enough for base and modulus.
   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold a bit position inside a w-bit exponent (at least 1).
   function automatic int idx_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/modexp_seq_if.sv
// Start/result bus plus the modular-multiply req/ack bus of the sequencer.
interface modexp_seq_if
   import modexp_seq_pkg::*;
#(
   parameter int base_width = 4,
   parameter int expo_width = 4,
   parameter int N_width    = 4
);
   localparam int op_width = max_w(base_width, N_width);

   logic                  start;
   logic [base_width-1:0] base;
   logic [expo_width-1:0] expo;
   logic [N_width-1:0]    N;
   logic                  busy;
   logic                  valid;
   logic                  err;
   logic [N_width-1:0]    result;
   logic                  mm_req;
   logic [op_width-1:0]   mm_a;
   logic [op_width-1:0]   mm_b;
   logic                  mm_ack;
   logic [N_width-1:0]    mm_rslt;

   // Sequencer side.
   modport slave (
      input  start, base, expo, N, mm_ack, mm_rslt,
      output busy, valid, err, result, mm_req, mm_a, mm_b
   );

   // Host / datapath side.
   modport master (
      output start, base, expo, N, mm_ack, mm_rslt,
      input  busy, valid, err, result, mm_req, mm_a, mm_b
   );
endinterface

// File: rtl/modexp_seq_expo_bit_scan.sv
// Exponent bit scanner: leading-one detector that seeds a down-counting bit
// index, plus the current exponent bit and an index-is-zero flag.
module expo_bit_scan
   import modexp_seq_pkg::*;
#(
   parameter int expo_width = 4,
   localparam int IW = idx_w(expo_width)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic                  dec_i,
   input  logic [expo_width-1:0] expo_i,
   output logic [IW-1:0]         idx_o,
   output logic                  cur_bit_o,
   output logic                  last_o
);
   logic [IW-1:0] idx_q;
   logic [IW-1:0] msb_d;

   // Position of the most significant set bit (0 when expo is 0).
   always_comb begin
      msb_d = '0;
      for (int i = 0; i < expo_width; i++) begin
         if (expo_i[i]) msb_d = IW'(i);
      end
   end

   // Bit index: seeded from the leading one, then walks toward bit 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (load_i) begin
         idx_q <= msb_d;
      end else if (dec_i && (idx_q != '0)) begin
         idx_q <= idx_q - 1'b1;
      end
   end

   assign idx_o     = idx_q;
   assign cur_bit_o = expo_i[idx_q];
   assign last_o    = (idx_q == '0);
endmodule

// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply sequencer driving a shared modular
// multiplier over a req/ack handshake. Trivial cases (N<=1, expo==0) are
// resolved without touching the multiplier.
module modexp_seq
   import modexp_seq_pkg::*;
#(
   parameter int base_width = 4,
   parameter int expo_width = 4,
   parameter int N_width    = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   modexp_seq_if.slave  bus
);
   localparam int op_width = max_w(base_width, N_width);
   localparam int IW       = idx_w(expo_width);

   state_e                state_q;
   logic                  busy_q, valid_q, err_q, mm_req_q;
   logic [N_width-1:0]    result_q;
   logic [op_width-1:0]   mm_a_q, mm_b_q;
   logic [base_width-1:0] base_q;
   logic [expo_width-1:0] expo_q;
   logic [N_width-1:0]    n_q, acc_q, acc_d, br_q;
   logic                  xfer, scan_load, scan_dec, cur_bit, last;
   // Bit index is exposed by the scanner for visibility; control only
   // needs cur_bit and last.
   logic [IW-1:0]         idx_unused;

   assign xfer      = mm_req_q & bus.mm_ack;
   assign scan_load = (state_q == ST_CHECK);
   assign scan_dec  = !last && (((state_q == ST_REDUCE) && xfer) || (state_q == ST_SCAN));

   expo_bit_scan #(.expo_width(expo_width)) u_scan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (scan_load),
      .dec_i     (scan_dec),
      .expo_i    (expo_q),
      .idx_o     (idx_unused),
      .cur_bit_o (cur_bit),
      .last_o    (last)
   );

   // Accumulator next value: trivial result in CHECK, multiplier result on ack.
   always_comb begin
      acc_d = acc_q;
      if (state_q == ST_CHECK) begin
         acc_d = ((n_q > N_width'(1)) && (expo_q == '0)) ? N_width'(1) : '0;
      end else if (xfer) begin
         acc_d = bus.mm_rslt;
      end
   end

   // Operand latches and arithmetic state; no reset needed, always written before use.
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
      if (xfer && (state_q == ST_REDUCE)) br_q <= bus.mm_rslt;
      if ((state_q == ST_IDLE) && bus.start) begin
         base_q <= bus.base;
         expo_q <= bus.expo;
         n_q    <= bus.N;
      end
   end

   // Control FSM with registered status and handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         mm_req_q <= 1'b0;
         mm_a_q   <= '0;
         mm_b_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  valid_q  <= 1'b0;
                  err_q    <= 1'b0;
                  result_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if ((n_q <= N_width'(1)) || (expo_q == '0)) state_q <= ST_DONE;
               else                                       state_q <= ST_REDUCE;
            end
            ST_REDUCE: begin
               if (!mm_req_q) begin
                  mm_req_q <= 1'b1;
                  mm_a_q   <= op_width'(base_q);
                  mm_b_q   <= op_width'(1);
               end else if (bus.mm_ack) begin
                  mm_req_q <= 1'b0;
                  state_q  <= last ? ST_DONE : ST_SQUARE;
               end
            end
            ST_SQUARE: begin
               if (!mm_req_q) begin
                  mm_req_q <= 1'b1;
                  mm_a_q   <= op_width'(acc_q);
                  mm_b_q   <= op_width'(acc_q);
               end else if (bus.mm_ack) begin
                  mm_req_q <= 1'b0;
                  state_q  <= cur_bit ? ST_MULT : ST_SCAN;
               end
            end
            ST_MULT: begin
               if (!mm_req_q) begin
                  mm_req_q <= 1'b1;
                  mm_a_q   <= op_width'(acc_q);
                  mm_b_q   <= op_width'(br_q);
               end else if (bus.mm_ack) begin
                  mm_req_q <= 1'b0;
                  state_q  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               state_q <= last ? ST_DONE : ST_SQUARE;
            end
            ST_DONE: begin
               result_q <= acc_q;
               valid_q  <= 1'b1;
               err_q    <= (n_q == '0);
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.valid  = valid_q;
   assign bus.err    = err_q;
   assign bus.result = result_q;
   assign bus.mm_req = mm_req_q;
   assign bus.mm_a   = mm_a_q;
   assign bus.mm_b   = mm_b_q;
endmodule

// File: tb/tb_modexp_seq.sv
// Bench for modexp_seq: table of exponentiations with a behavioural modular
// multiplier, a result scoreboard, and hand-written corner sequences.
module tb_modexp_seq;
   import modexp_seq_pkg::*;

   localparam int BW = 4;
   localparam int EW = 4;
   localparam int NW = 4;
   localparam int OW = max_w(BW, NW);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   modexp_seq_if #(.base_width(BW), .expo_width(EW), .N_width(NW)) bus ();

   modexp_seq #(.base_width(BW), .expo_width(EW), .N_width(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] base;
      logic [3:0] expo;
      logic [3:0] n;
      int         lat;   // 0 = random 1..5
      logic [3:0] res;
      logic       err;
      int         ntx;
   } vec_t;

   typedef struct {
      logic [3:0] res;
      logic       err;
      int         ntx;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Datapath model controls and observations.
   int   lat_cfg   = 2;
   bit   dp_en     = 1'b1;
   bit   stale_ack = 1'b0;
   int   tx_cnt    = 0;
   int   stab_bad  = 0;
   int   cur_n     = 1;
   logic [OW-1:0] log_a[$];
   logic [OW-1:0] log_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Behavioural modular multiplier: configurable ack latency, one-cycle ack.
   initial begin : dp
      bit in_tx;
      bit ack_now;
      int cnt;
      logic [OW-1:0] a0, b0;
      in_tx = 1'b0; ack_now = 1'b0; cnt = 0; a0 = '0; b0 = '0;
      bus.mm_ack  = 1'b0;
      bus.mm_rslt = '0;
      forever begin
         @(negedge clk);
         if (ack_now) begin
            bus.mm_ack = 1'b0;
            ack_now    = 1'b0;
         end else if (stale_ack) begin
            bus.mm_ack  = 1'b1;
            bus.mm_rslt = '1;
            ack_now     = 1'b1;
            stale_ack   = 1'b0;
         end else if (!dp_en) begin
            in_tx = 1'b0;
         end else if (bus.mm_req === 1'b1) begin
            if (!in_tx) begin
               in_tx = 1'b1;
               cnt   = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 5));
               a0    = bus.mm_a;
               b0    = bus.mm_b;
               tx_cnt++;
               log_a.push_back(a0);
               log_b.push_back(b0);
            end else if ((bus.mm_a !== a0) || (bus.mm_b !== b0)) begin
               stab_bad++;
            end
            cnt--;
            if (cnt <= 0) begin
               bus.mm_ack  = 1'b1;
               bus.mm_rslt = (cur_n == 0) ? '0 : NW'((int'(a0) * int'(b0)) % cur_n);
               in_tx       = 1'b0;
               ack_now     = 1'b1;
            end
         end
      end
   end

   task automatic start_op(input logic [3:0] b, input logic [3:0] e, input logic [3:0] n,
                           input logic [3:0] res, input logic err, input int ntx, input bit push);
      exp_t x;
      x.res = res; x.err = err; x.ntx = ntx;
      if (push) sb_q.push_back(x);
      cur_n    = int'(n);
      tx_cnt   = 0;
      stab_bad = 0;
      log_a.delete();
      log_b.delete();
      @(negedge clk);
      bus.base  = b;
      bus.expo  = e;
      bus.N     = n;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.base  = 4'($urandom);
      bus.expo  = 4'($urandom);
      bus.N     = 4'($urandom);
   endtask

   task automatic wait_result(input string tag);
      exp_t e;
      int   cyc;
      cyc = 0;
      while ((bus.valid !== 1'b1) && (cyc < 3000)) begin
         @(negedge clk);
         cyc++;
      end
      if (bus.valid !== 1'b1) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s timeout: valid=%b, required 1", tag, bus.valid);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         return;
      end
      e = sb_q.pop_front();
      check($sformatf("%s result", tag), 32'(bus.result), 32'(e.res));
      check($sformatf("%s err", tag), 32'(bus.err), 32'(e.err));
      check($sformatf("%s mm_count", tag), 32'(tx_cnt), 32'(e.ntx));
      check($sformatf("%s busy_at_valid", tag), 32'(bus.busy), 32'd0);
      check($sformatf("%s operand_stable", tag), 32'(stab_bad), 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t vecs[11];
      int   pa[4];
      int   pb[4];
      vecs[0]  = '{4'd3,  4'd5,  4'd7,  2, 4'd5,  1'b0, 4};
      vecs[1]  = '{4'd15, 4'd15, 4'd13, 0, 4'd8,  1'b0, 7};
      vecs[2]  = '{4'd4,  4'd0,  4'd5,  1, 4'd1,  1'b0, 0};
      vecs[3]  = '{4'd6,  4'd9,  4'd1,  1, 4'd0,  1'b0, 0};
      vecs[4]  = '{4'd5,  4'd3,  4'd0,  1, 4'd0,  1'b1, 0};
      vecs[5]  = '{4'd14, 4'd3,  4'd7,  3, 4'd0,  1'b0, 3};
      vecs[6]  = '{4'd2,  4'd15, 4'd11, 1, 4'd10, 1'b0, 7};
      vecs[7]  = '{4'd9,  4'd1,  4'd5,  0, 4'd4,  1'b0, 1};
      vecs[8]  = '{4'd7,  4'd8,  4'd15, 2, 4'd1,  1'b0, 4};
      vecs[9]  = '{4'd15, 4'd2,  4'd15, 1, 4'd0,  1'b0, 2};
      vecs[10] = '{4'd10, 4'd6,  4'd9,  0, 4'd1,  1'b0, 4};
      pa = '{3, 3, 2, 4};
      pb = '{1, 3, 2, 3};

      bus.start = 1'b0;
      bus.base  = '0;
      bus.expo  = '0;
      bus.N     = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst valid", 32'(bus.valid), 32'd0);
      check("rst err", 32'(bus.err), 32'd0);
      check("rst result", 32'(bus.result), 32'd0);
      check("rst mm_req", 32'(bus.mm_req), 32'd0);
      check("rst mm_a", 32'(bus.mm_a), 32'd0);
      check("rst mm_b", 32'(bus.mm_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table of exponentiations
      for (int i = 0; i < 11; i++) begin
         lat_cfg = vecs[i].lat;
         start_op(vecs[i].base, vecs[i].expo, vecs[i].n, vecs[i].res, vecs[i].err, vecs[i].ntx, 1'b1);
         wait_result($sformatf("vec%0d", i));
         if (i == 0) begin
            check("vec0 log_size", 32'(log_a.size()), 32'd4);
            for (int k = 0; k < 4 && k < log_a.size(); k++) begin
               check($sformatf("vec0 tx%0d mm_a", k), 32'(log_a[k]), 32'(pa[k]));
               check($sformatf("vec0 tx%0d mm_b", k), 32'(log_b[k]), 32'(pb[k]));
            end
         end
      end

      // Result held in IDLE, then cleared by the next accepted start
      repeat (5) @(negedge clk);
      check("hold valid", 32'(bus.valid), 32'd1);
      check("hold result", 32'(bus.result), 32'd1);

      // expo==0: valid exactly two cycles after the start edge
      lat_cfg = 1;
      start_op(4'd9, 4'd0, 4'd5, 4'd1, 1'b0, 0, 1'b1);
      check("triv valid_clear", 32'(bus.valid), 32'd0);
      check("triv result_clear", 32'(bus.result), 32'd0);
      check("triv busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("triv valid_c1", 32'(bus.valid), 32'd0);
      @(negedge clk);
      check("triv valid_c2", 32'(bus.valid), 32'd1);
      wait_result("triv");

      // start while busy with other operands is ignored
      lat_cfg = 2;
      start_op(4'd3, 4'd5, 4'd7, 4'd5, 1'b0, 4, 1'b1);
      repeat (3) @(negedge clk);
      bus.base  = 4'd2;
      bus.expo  = 4'd3;
      bus.N     = 4'd11;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_start busy", 32'(bus.busy), 32'd1);
      wait_result("busy_start");

      // Reset during SQUARE with mm_req high, then a stale ack
      lat_cfg = 20;
      start_op(4'd3, 4'd5, 4'd7, 4'd0, 1'b0, 0, 1'b0);
      for (int c = 0; c < 300 && !((tx_cnt == 2) && (bus.mm_req === 1'b1)); c++) @(negedge clk);
      check("mid_rst req_before", 32'(bus.mm_req), 32'd1);
      check("mid_rst tx_before", 32'(tx_cnt), 32'd2);
      dp_en = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst mm_req", 32'(bus.mm_req), 32'd0);
      check("mid_rst busy", 32'(bus.busy), 32'd0);
      check("mid_rst valid", 32'(bus.valid), 32'd0);
      rst_n     = 1'b1;
      stale_ack = 1'b1;
      repeat (4) @(negedge clk);
      check("stale busy", 32'(bus.busy), 32'd0);
      check("stale valid", 32'(bus.valid), 32'd0);
      check("stale mm_req", 32'(bus.mm_req), 32'd0);
      check("stale result", 32'(bus.result), 32'd0);
      dp_en   = 1'b1;
      lat_cfg = 1;
      start_op(4'd3, 4'd5, 4'd7, 4'd5, 1'b0, 4, 1'b1);
      wait_result("recover");

      check("scoreboard empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
